// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared types, widths and helpers for the uart_tx arbiter
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, SEND, LOCK} state_t;

  localparam int DATA_W = 8;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - wrapping priority search starting at ptr
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 3,
  localparam int GW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic          any,
  output logic [GW-1:0] idx
);

  always_comb begin
    int j;
    any = 1'b0;
    idx = '0;
    j   = 0;
    // Wrap explicitly so non-power-of-2 N never yields an index >= N
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = GW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-locked sharing of one uart_tx among N producers
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N            = 3,
  parameter int LOCK_TIMEOUT = 1023,
  localparam int GW          = idx_w(N)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N-1:0]        req_vld,
  input  logic [DATA_W*N-1:0] req_data,
  input  logic [N-1:0]        req_last,
  output logic [N-1:0]        req_rdy,
  input  logic                rdy_tx,
  output logic                vld_tx,
  output logic [DATA_W-1:0]   d_tx,
  output logic [GW-1:0]       gnt_id,
  output logic                busy,
  output logic                lock_to
);

  localparam int TW                = (LOCK_TIMEOUT <= 2) ? 1 : $clog2(LOCK_TIMEOUT);
  localparam logic [TW-1:0] TMR_END = TW'(LOCK_TIMEOUT - 1);
  localparam logic [GW-1:0] IDX_END = GW'(N - 1);

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr, ptr_adv, pick_idx, sel_idx;
  logic [TW-1:0] tmr;
  logic [N-1:0]  rdy_c;
  logic          last_q, pick_any, accept, expire, release_own;

  rr_pick #(.N(N)) u_pick (
    .req (req_vld),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign ptr_adv = (gnt_id == IDX_END) ? '0 : gnt_id + GW'(1);
  assign req_rdy = rstn ? rdy_c : '0;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    rdy_c       = '0;
    sel_idx     = pick_idx;
    accept      = 1'b0;
    expire      = 1'b0;
    release_own = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          rdy_c     = N'(1) << pick_idx;
          accept    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (rdy_tx) begin
          state_nxt   = last_q ? IDLE : LOCK;
          release_own = last_q;
        end
      end
      LOCK: begin
        // Only the owner may continue; its byte beats a coincident timeout
        rdy_c   = N'(1) << gnt_id;
        sel_idx = gnt_id;
        if (req_vld[gnt_id]) begin
          accept    = 1'b1;
          state_nxt = SEND;
        end else if (tmr == TMR_END) begin
          expire      = 1'b1;
          release_own = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      vld_tx  <= 1'b0;
      d_tx    <= '0;
      gnt_id  <= '0;
      rr_ptr  <= '0;
      last_q  <= 1'b0;
      tmr     <= '0;
      lock_to <= 1'b0;
    end else begin
      state   <= state_nxt;
      lock_to <= expire;
      if (accept) begin
        d_tx   <= req_data[sel_idx*DATA_W +: DATA_W];
        last_q <= req_last[sel_idx];
        gnt_id <= sel_idx;
        vld_tx <= 1'b1;
      end
      if (state == SEND && rdy_tx) begin
        vld_tx <= 1'b0;
        if (!last_q) tmr <= '0;
      end
      if (release_own) rr_ptr <= ptr_adv;
      if (state == LOCK && !accept && !expire) tmr <= tmr + TW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter against a message-level model
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  req_vld;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_rdy;
  logic        rdy_tx;
  logic        vld_tx;
  logic [7:0]  d_tx;
  logic [1:0]  gnt_id;
  logic        busy;
  logic        lock_to;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .LOCK_TIMEOUT(TO)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_vld  (req_vld),
    .req_data (req_data),
    .req_last (req_last),
    .req_rdy  (req_rdy),
    .rdy_tx   (rdy_tx),
    .vld_tx   (vld_tx),
    .d_tx     (d_tx),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .lock_to  (lock_to)
  );

  logic [7:0] qd[3][$];
  bit         ql[3][$];
  logic [7:0] exp_d[$];
  int         exp_o[$];
  logic [7:0] got_d[$];
  int         got_o[$];
  int         got_t[$];
  int         lock_seen[$];
  int         rdy_cnt[3];
  int         checks = 0;
  int         fails = 0;
  int         m_ptr = 0;
  int         rdy_mode = 1;
  int         tick_n = 0;
  bit         prev_xfer = 1'b0;
  logic [2:0] en = 3'b111;
  logic       s_vld;
  logic [7:0] s_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int src, input logic [7:0] b, input bit last);
    qd[src].push_back(b);
    ql[src].push_back(last);
  endtask

  task automatic push_msg(input int src, input string s);
    for (int k = 0; k < s.len(); k++) push_byte(src, s[k], k == s.len() - 1);
  endtask

  function automatic bit all_empty();
    return qd[0].size() == 0 && qd[1].size() == 0 && qd[2].size() == 0;
  endfunction

  // Whole messages are granted in rotation starting at the model pointer
  task automatic model_build();
    int ptr;
    int pos[3];
    int c;
    bit found;
    bit done;
    ptr = m_ptr;
    pos = '{0, 0, 0};
    exp_d.delete();
    exp_o.delete();
    done = 1'b0;
    while (!done) begin
      found = 1'b0;
      c = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && pos[(ptr + k) % N] < qd[(ptr + k) % N].size()) begin
          found = 1'b1;
          c = (ptr + k) % N;
        end
      end
      if (!found) begin
        done = 1'b1;
      end else begin
        do begin
          exp_d.push_back(qd[c][pos[c]]);
          exp_o.push_back(c);
          pos[c]++;
        end while (!ql[c][pos[c] - 1] && pos[c] < qd[c].size());
        ptr = (c + 1) % N;
      end
    end
    m_ptr = ptr;
  endtask

  task automatic tick();
    logic [2:0] fire;
    bit xfer;
    for (int i = 0; i < N; i++) begin
      req_vld[i]         = en[i] && qd[i].size() > 0;
      req_data[8*i +: 8] = (qd[i].size() > 0) ? qd[i][0] : 8'h00;
      req_last[i]        = (ql[i].size() > 0) ? ql[i][0] : 1'b0;
    end
    rdy_tx = (rdy_mode == 2) ? ($urandom_range(0, 9) < 7) : (rdy_mode == 1);
    #1;
    fire  = req_vld & req_rdy;
    xfer  = vld_tx & rdy_tx;
    s_vld = vld_tx;
    s_d   = d_tx;
    if (xfer) begin
      chk("spacing", prev_xfer, 1'b0);
      got_d.push_back(d_tx);
      got_o.push_back(int'(gnt_id));
      got_t.push_back(tick_n);
    end
    prev_xfer = xfer;
    for (int i = 0; i < N; i++) if (req_rdy[i]) rdy_cnt[i]++;
    if (lock_to) lock_seen.push_back(tick_n);
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
    end
    tick_n++;
    @(negedge clk);
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while (n < budget && !(all_empty() && !busy && !vld_tx)) begin
      tick();
      n++;
    end
    chk("drain_in_budget", n < budget, 1'b1);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, got_d.size(), exp_d.size());
    for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
      chk({tag, "_byte"}, got_d[k], exp_d[k]);
      chk({tag, "_owner"}, got_o[k], exp_o[k]);
    end
    got_d.delete();
    got_o.delete();
    got_t.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int stable;
    rstn     = 1'b0;
    req_vld  = 3'b111;
    req_data = 24'h433231;
    req_last = 3'b111;
    rdy_tx   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_rdy", req_rdy, 3'b000);
    chk("rst_vld_tx", vld_tx, 1'b0);
    chk("rst_d_tx", d_tx, 8'h00);
    chk("rst_gnt_id", gnt_id, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_lock_to", lock_to, 1'b0);
    @(negedge clk);
    req_vld = 3'b000;
    rstn    = 1'b1;

    // Contention: two rounds of simultaneous single-byte messages
    for (int r = 0; r < 2; r++) begin
      push_msg(0, "A");
      push_msg(1, "B");
      push_msg(2, "C");
    end
    rdy_cnt = '{0, 0, 0};
    model_build();
    run_until_empty(100);
    compare("contention");
    for (int i = 0; i < N; i++) chk("contention_rdy_cnt", rdy_cnt[i], 2);

    // Single byte message
    push_msg(0, "1");
    rdy_cnt = '{0, 0, 0};
    model_build();
    run_until_empty(50);
    compare("single");
    chk("single_rdy_cnt", rdy_cnt[0], 1);
    chk("single_busy", busy, 1'b0);

    // Locked word against a competing requester
    push_msg(0, "x");
    push_msg(1, "0000_0031");
    model_build();
    run_until_empty(100);
    compare("word");

    // Lock timeout: owner 2 goes silent after one non-last byte
    push_byte(2, 8'h55, 1'b0);
    push_msg(0, "p");
    lock_seen.delete();
    n = 0;
    while (n < 80 && !(got_d.size() >= 2 && !busy && !vld_tx)) begin
      tick();
      n++;
    end
    chk("to_budget", n < 80, 1'b1);
    chk("to_count", got_d.size(), 2);
    chk("to_pulses", lock_seen.size(), 1);
    if (got_d.size() >= 2 && lock_seen.size() >= 1) begin
      chk("to_first_byte", got_d[0], 8'h55);
      chk("to_first_owner", got_o[0], 2);
      chk("to_delay", lock_seen[0] - got_t[0], TO + 1);
      chk("to_next_byte", got_d[1], "p");
      chk("to_next_owner", got_o[1], 0);
      chk("to_next_after_pulse", got_t[1] > lock_seen[0], 1'b1);
    end
    got_d.delete();
    got_o.delete();
    got_t.delete();
    m_ptr = 1;
    push_msg(1, "q");
    push_byte(2, 8'h66, 1'b1);
    model_build();
    run_until_empty(50);
    compare("rearb");

    // Stall in SEND for 20 cycles
    push_msg(2, "Z");
    model_build();
    rdy_mode = 0;
    n = 0;
    while (n < 10 && vld_tx !== 1'b1) begin
      tick();
      n++;
    end
    stable = 0;
    repeat (20) begin
      tick();
      if (s_vld === 1'b1 && s_d === "Z") stable++;
    end
    chk("stall_stable", stable, 20);
    chk("stall_no_xfer", got_d.size(), 0);
    rdy_mode = 1;
    run_until_empty(20);
    compare("stall");

    // Randomised messages with random uart_tx back-pressure
    for (int it = 0; it < 4; it++) begin
      for (int s = 0; s < N; s++) begin
        int nm;
        nm = $urandom_range(0, 3);
        for (int m = 0; m < nm; m++) begin
          int len;
          len = $urandom_range(1, 5);
          for (int b = 0; b < len; b++) push_byte(s, 8'($urandom), b == len - 1);
        end
      end
      rdy_mode = 2;
      model_build();
      run_until_empty(3000);
      compare("random");
    end
    rdy_mode = 1;

    // Reset in the middle of a locked 4-byte message
    push_msg(1, "k");
    model_build();
    run_until_empty(50);
    compare("pre_reset");
    push_msg(1, "wxyz");
    n = 0;
    while (qd[1].size() == 4 && n < 20) begin
      tick();
      n++;
    end
    en[1] = 1'b0;
    n = 0;
    while (got_d.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk("mid_locked_busy", busy, 1'b1);
    en[1]    = 1'b1;
    req_vld  = 3'b010;
    #2 rstn  = 1'b0;
    #1;
    chk("mid_rst_req_rdy", req_rdy, 3'b000);
    chk("mid_rst_vld_tx", vld_tx, 1'b0);
    chk("mid_rst_d_tx", d_tx, 8'h00);
    chk("mid_rst_gnt_id", gnt_id, 2'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_lock_to", lock_to, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    qd[1].delete();
    ql[1].delete();
    got_d.delete();
    got_o.delete();
    got_t.delete();
    prev_xfer = 1'b0;
    m_ptr = 0;
    push_msg(0, "r");
    push_msg(2, "s");
    model_build();
    run_until_empty(50);
    compare("post_reset");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
